// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse measurement receiver: FSM encoding and the
// default timing constants agreed with the square-wave pulse generator.
package pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAS = 2'd1,
    ST_LOST = 2'd2
  } meas_state_t;

  // Generator Period register value; the generator adds one cycle per period.
  localparam int GEN_PERIOD     = 32'sd14746;
  localparam int DEF_CNT_W      = 32'sd16;
  localparam int DEF_EXP_PERIOD = GEN_PERIOD + 32'sd1;
  localparam int DEF_TOL        = 32'sd64;
  localparam int DEF_LOCK_CNT   = 32'sd4;
  localparam int DEF_TIMEOUT    = 32'sd2 * DEF_EXP_PERIOD;

endpackage

// File: rtl/pulse_sync_edge.sv
// Two-flop synchroniser for an asynchronous input followed by a delay flop
// that produces single-cycle rise/fall strobes in the clk domain.
module pulse_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic d_sync,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchroniser chain plus one stage of history for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= d_async;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign d_sync = sync_r;
  assign rise   = sync_r & ~prev_r;
  assign fall   = ~sync_r & prev_r;

endmodule

// File: rtl/pulse_meas.sv
// Measures period and high time of an asynchronous square wave in clk cycles,
// reports lock to the expected period and loss of edges.
module pulse_meas
  import pulse_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int EXP_PERIOD = DEF_EXP_PERIOD,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             lost
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 32'sd1);
  localparam int DW     = CNT_W + 32'sd1;

  localparam logic [CNT_W-1:0]     ONE_C      = CNT_W'(1);
  localparam logic [CNT_W-1:0]     TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]     LAST_C     = CNT_W'(TIMEOUT - 32'sd1);
  localparam logic signed [DW-1:0] EXP_C      = DW'(EXP_PERIOD);
  localparam logic signed [DW-1:0] TOL_HI_C   = DW'(TOL);
  localparam logic signed [DW-1:0] TOL_LO_C   = DW'(-TOL);
  localparam logic [GOOD_W-1:0]    LOCK_C     = GOOD_W'(LOCK_CNT);
  localparam logic [GOOD_W-1:0]    GOOD_ONE_C = GOOD_W'(1);

  logic                 rise_s;
  logic                 fall_s;
  logic                 sync_unused_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_p1_s;
  logic [CNT_W-1:0]     hcap_r;
  logic signed [DW-1:0] diff_s;
  logic                 in_tol_s;
  logic                 timeout_s;

  meas_state_t          state_r;
  meas_state_t          state_nxt_s;
  logic [GOOD_W-1:0]    good_r;
  logic [GOOD_W-1:0]    good_nxt_s;
  logic [CNT_W-1:0]     period_r;
  logic [CNT_W-1:0]     period_nxt_s;
  logic [CNT_W-1:0]     high_r;
  logic [CNT_W-1:0]     high_nxt_s;
  logic                 valid_r;
  logic                 valid_nxt_s;
  logic                 locked_r;
  logic                 locked_nxt_s;
  logic                 lost_r;
  logic                 lost_nxt_s;

  pulse_sync_edge u_sync (
    .clk     (clk),
    .rst     (rst),
    .d_async (pulse_in),
    .d_sync  (sync_unused_s),
    .rise    (rise_s),
    .fall    (fall_s)
  );

  assign cnt_p1_s = cnt_r + ONE_C;
  assign diff_s   = $signed({1'b0, cnt_p1_s}) - EXP_C;
  assign in_tol_s = (diff_s >= TOL_LO_C) && (diff_s <= TOL_HI_C);
  // lost registers on the same edge that cnt reaches TIMEOUT
  assign timeout_s = (cnt_r >= LAST_C);

  // Cycle counter restarted by each rise and saturating at TIMEOUT; high-time capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= '0;
      hcap_r <= '0;
    end else begin
      if (rise_s) begin
        cnt_r <= '0;
      end else if (cnt_r < TIMEOUT_C) begin
        cnt_r <= cnt_p1_s;
      end else begin
        cnt_r <= cnt_r;
      end
      if (fall_s) begin
        hcap_r <= cnt_p1_s;
      end else begin
        hcap_r <= hcap_r;
      end
    end
  end

  // Next-state, lock counter and output updates
  always_comb begin
    state_nxt_s  = state_r;
    good_nxt_s   = good_r;
    period_nxt_s = period_r;
    high_nxt_s   = high_r;
    valid_nxt_s  = 1'b0;
    locked_nxt_s = locked_r;
    lost_nxt_s   = lost_r;
    case (state_r)
      ST_IDLE: begin
        if (rise_s) begin
          state_nxt_s = ST_MEAS;
        end else if (timeout_s) begin
          state_nxt_s  = ST_LOST;
          lost_nxt_s   = 1'b1;
          locked_nxt_s = 1'b0;
          good_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MEAS: begin
        if (rise_s) begin
          valid_nxt_s  = 1'b1;
          period_nxt_s = cnt_p1_s;
          high_nxt_s   = hcap_r;
          if (in_tol_s) begin
            if (good_r < LOCK_C) begin
              good_nxt_s = good_r + GOOD_ONE_C;
            end else begin
              good_nxt_s = LOCK_C;
            end
            locked_nxt_s = (good_nxt_s == LOCK_C);
          end else begin
            good_nxt_s   = '0;
            locked_nxt_s = 1'b0;
          end
        end else if (timeout_s) begin
          state_nxt_s  = ST_LOST;
          lost_nxt_s   = 1'b1;
          locked_nxt_s = 1'b0;
          good_nxt_s   = '0;
        end else begin
          state_nxt_s = ST_MEAS;
        end
      end
      ST_LOST: begin
        // first rise only restarts the measurement
        if (rise_s) begin
          state_nxt_s = ST_MEAS;
          lost_nxt_s  = 1'b0;
        end else begin
          lost_nxt_s   = 1'b1;
          locked_nxt_s = 1'b0;
          good_nxt_s   = '0;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        lost_nxt_s   = 1'b0;
        locked_nxt_s = 1'b0;
        good_nxt_s   = '0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      good_r   <= '0;
      period_r <= '0;
      high_r   <= '0;
      valid_r  <= 1'b0;
      locked_r <= 1'b0;
      lost_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      good_r   <= good_nxt_s;
      period_r <= period_nxt_s;
      high_r   <= high_nxt_s;
      valid_r  <= valid_nxt_s;
      locked_r <= locked_nxt_s;
      lost_r   <= lost_nxt_s;
    end
  end

  assign period     = period_r;
  assign high_time  = high_r;
  assign meas_valid = valid_r;
  assign locked     = locked_r;
  assign lost       = lost_r;

endmodule

// File: tb/tb_pulse_meas.sv
// Self-checking bench for pulse_meas: an event-level model predicts strobes and
// lost transitions from the pin waveform; a monitor records what the DUT does.
module tb_pulse_meas;

  localparam int CNT_W  = 8;
  localparam int EXP_P  = 20;
  localparam int TOL    = 2;
  localparam int LOCK_N = 3;
  localparam int TMO    = 40;
  localparam int LAT    = 3;

  logic             clk      = 1'b0;
  logic             rst      = 1'b1;
  logic             pulse_in = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             lost;

  int cyc   = 0;
  int n_tot = 0;
  int n_bad = 0;

  // event: {type, cycle, period, high_time, locked}; 1=strobe 2=lost set 3=lost clear 0=stray locked change
  logic [34:0] exp_q[$];
  logic [34:0] obs_q[$];

  int   rise_m = 0;
  int   fall_m = 0;
  int   good_m = 0;
  logic pin_m  = 1'b0;
  logic lost_m = 1'b0;
  logic meas_m = 1'b0;
  logic lock_m = 1'b0;
  logic lost_prev = 1'b0;
  logic locked_prev = 1'b0;

  pulse_meas #(
    .CNT_W      (CNT_W),
    .EXP_PERIOD (EXP_P),
    .TOL        (TOL),
    .LOCK_CNT   (LOCK_N),
    .TIMEOUT    (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pulse_in   (pulse_in),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .lost       (lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record strobes, lost transitions and any locked change outside them
  always @(negedge clk) begin
    if (rst) begin
      lost_prev   <= 1'b0;
      locked_prev <= 1'b0;
    end else begin
      if (meas_valid) obs_q.push_back({2'd1, 16'(cyc), period, high_time, locked});
      if (lost !== lost_prev) obs_q.push_back({(lost ? 2'd2 : 2'd3), 16'(cyc), 8'd0, 8'd0, locked});
      if ((locked !== locked_prev) && !meas_valid && !(lost && !lost_prev))
        obs_q.push_back({2'd0, 16'(cyc), 8'd0, 8'd0, locked});
      lost_prev   <= lost;
      locked_prev <= locked;
    end
  end

  function automatic logic [34:0] ev(input logic [1:0] t, input int c, input int p, input int h, input logic l);
    return {t, 16'(c), 8'(p), 8'(h), l};
  endfunction

  // Reset release behaves like a rise seen LAT cycles earlier, with no measurement pending
  task automatic model_reset();
    rise_m = cyc - LAT;
    fall_m = cyc;
    pin_m  = 1'b0;
    lost_m = 1'b0;
    meas_m = 1'b0;
    good_m = 0;
    lock_m = 1'b0;
  endtask

  task automatic drive(input logic v);
    int p;
    int hh;
    @(posedge clk);
    #2;
    pulse_in = v;
    if (v && !pin_m) begin
      if (lost_m) begin
        lost_m = 1'b0;
        meas_m = 1'b1;
        exp_q.push_back(ev(2'd3, cyc + LAT, 0, 0, 1'b0));
      end else if (meas_m) begin
        p  = cyc - rise_m;
        hh = fall_m - rise_m;
        if (p >= EXP_P - TOL && p <= EXP_P + TOL) begin
          if (good_m < LOCK_N) good_m = good_m + 1;
          lock_m = (good_m == LOCK_N);
        end else begin
          good_m = 0;
          lock_m = 1'b0;
        end
        exp_q.push_back(ev(2'd1, cyc + LAT, p, hh, lock_m));
      end else begin
        meas_m = 1'b1;
      end
      rise_m = cyc;
    end else begin
      if (!v && pin_m) fall_m = cyc;
      if (!lost_m && (cyc - rise_m == TMO)) begin
        lost_m = 1'b1;
        meas_m = 1'b0;
        good_m = 0;
        lock_m = 1'b0;
        exp_q.push_back(ev(2'd2, cyc + LAT, 0, 0, 1'b0));
      end
    end
    pin_m = v;
  endtask

  task automatic wave(input int h, input int l);
    repeat (h) drive(1'b1);
    repeat (l) drive(1'b0);
  endtask

  task automatic test_reset();
    logic [18:0] got;
    logic [18:0] want;
    logic [34:0] got_e;
    logic [34:0] want_e;
    rst = 1'b1;
    pulse_in = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    for (int k = 1; k <= 50; k++) begin
      drive(1'b0);
      @(negedge clk);
      got  = {period, high_time, meas_valid, locked, lost};
      want = {8'd0, 8'd0, 1'b0, 1'b0, ((k >= TMO) ? 1'b1 : 1'b0)};
      n_tot++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL reset_idle k=%0d: got %h expected %h", k, got, want);
      end
    end
    n_tot++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL reset_count: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      want_e = exp_q.pop_front();
      if (obs_q.size() > 0) got_e = obs_q.pop_front(); else got_e = '0;
      n_tot++;
      if (got_e !== want_e) begin
        n_bad++;
        $display("FAIL reset_event: got %h expected %h", got_e, want_e);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_square();
    logic [34:0] got_e;
    logic [34:0] want_e;
    repeat (6) wave(8, 12);
    n_tot++;
    if ({period, high_time, locked, lost} !== {8'd20, 8'd8, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL square_final: got p=%0d h=%0d lk=%b ls=%b expected p=20 h=8 lk=1 ls=0",
               period, high_time, locked, lost);
    end
    n_tot++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL square_count: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      want_e = exp_q.pop_front();
      if (obs_q.size() > 0) got_e = obs_q.pop_front(); else got_e = '0;
      n_tot++;
      if (got_e !== want_e) begin
        n_bad++;
        $display("FAIL square_event: got %h expected %h", got_e, want_e);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_unlock();
    logic [34:0] got_e;
    logic [34:0] want_e;
    wave(8, 17);
    repeat (4) wave(8, 12);
    n_tot++;
    if ({period, locked} !== {8'd20, 1'b1}) begin
      n_bad++;
      $display("FAIL unlock_relock: got p=%0d lk=%b expected p=20 lk=1", period, locked);
    end
    n_tot++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL unlock_count: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      want_e = exp_q.pop_front();
      if (obs_q.size() > 0) got_e = obs_q.pop_front(); else got_e = '0;
      n_tot++;
      if (got_e !== want_e) begin
        n_bad++;
        $display("FAIL unlock_event: got %h expected %h", got_e, want_e);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_tolerance();
    logic [34:0] got_e;
    logic [34:0] want_e;
    int per[6];
    per = '{17, 18, 22, 18, 23, 20};
    foreach (per[i]) wave(8, per[i] - 8);
    n_tot++;
    if ({period, locked} !== {8'd23, 1'b0}) begin
      n_bad++;
      $display("FAIL tol_final: got p=%0d lk=%b expected p=23 lk=0", period, locked);
    end
    n_tot++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL tol_count: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      want_e = exp_q.pop_front();
      if (obs_q.size() > 0) got_e = obs_q.pop_front(); else got_e = '0;
      n_tot++;
      if (got_e !== want_e) begin
        n_bad++;
        $display("FAIL tol_event: got %h expected %h", got_e, want_e);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_stuck();
    logic [34:0] got_e;
    logic [34:0] want_e;
    repeat (4) wave(8, 12);
    repeat (50) drive(1'b1);
    @(negedge clk);
    n_tot++;
    if ({lost, locked} !== 2'b10) begin
      n_bad++;
      $display("FAIL stuck_lost: got ls=%b lk=%b expected ls=1 lk=0", lost, locked);
    end
    repeat (5) drive(1'b0);
    repeat (2) wave(8, 12);
    n_tot++;
    if ({lost, period} !== {1'b0, 8'd20}) begin
      n_bad++;
      $display("FAIL stuck_recover: got ls=%b p=%0d expected ls=0 p=20", lost, period);
    end
    n_tot++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL stuck_count: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      want_e = exp_q.pop_front();
      if (obs_q.size() > 0) got_e = obs_q.pop_front(); else got_e = '0;
      n_tot++;
      if (got_e !== want_e) begin
        n_bad++;
        $display("FAIL stuck_event: got %h expected %h", got_e, want_e);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_async_reset();
    logic [34:0] got_e;
    logic [34:0] want_e;
    repeat (3) wave(8, 12);
    repeat (8) drive(1'b1);
    repeat (5) drive(1'b0);
    n_tot++;
    if (locked !== 1'b1) begin
      n_bad++;
      $display("FAIL arst_prelock: got lk=%b expected lk=1", locked);
    end
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    n_tot++;
    if ({period, high_time, meas_valid, locked, lost} !== 19'd0) begin
      n_bad++;
      $display("FAIL arst_immediate: got p=%0d h=%0d v=%b lk=%b ls=%b expected all 0",
               period, high_time, meas_valid, locked, lost);
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    repeat (3) wave(8, 12);
    n_tot++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL arst_count: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      want_e = exp_q.pop_front();
      if (obs_q.size() > 0) got_e = obs_q.pop_front(); else got_e = '0;
      n_tot++;
      if (got_e !== want_e) begin
        n_bad++;
        $display("FAIL arst_event: got %h expected %h", got_e, want_e);
      end
    end
    obs_q.delete();
  endtask

  task automatic test_random();
    logic [34:0] got_e;
    logic [34:0] want_e;
    int h;
    int p;
    for (int i = 0; i < 40; i++) begin
      h = $urandom_range(2, 8);
      if ($urandom_range(0, 9) == 0) p = $urandom_range(38, 46);
      else p = $urandom_range(16, 24);
      wave(h, p - h);
    end
    repeat (5) drive(1'b0);
    n_tot++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL random_count: got %0d events expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      want_e = exp_q.pop_front();
      if (obs_q.size() > 0) got_e = obs_q.pop_front(); else got_e = '0;
      n_tot++;
      if (got_e !== want_e) begin
        n_bad++;
        $display("FAIL random_event: got %h expected %h", got_e, want_e);
      end
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_square();
    test_unlock();
    test_tolerance();
    test_stuck();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by 2000000 ns expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
